eth_rx_framer: RTL and testbench
================================

# eth_rx_framer

Receive-side framing stage that sits directly upstream of the Ethernet APB peripheral's RX buffer. It consumes a byte stream already synchronised into the system clock domain and writes each frame byte-by-byte into the RX buffer's write port. It checks frame length and the Ethernet FCS (CRC-32), then signals a completed good frame with its payload length to the APB block. It drops frames while the host still owns the buffer, and keeps saturating drop/error counters.

## Interface
Parameters:
- MTU, 1536: RX buffer depth in bytes; equals the codebase's ETHERNET_MTU.
- LEN_W, 16: width of address, length and counter outputs.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- s_data  in  8  received byte, first byte = destination MAC[0].
- s_valid  in  1  byte valid; there is no backpressure. s_valid is contiguous from the first byte to the last byte of a frame.
- s_last  in  1  qualifies the final byte (last FCS byte); valid only with s_valid.
- s_err  in  1  PHY error flag on this byte; valid only with s_valid.
- host_busy  in  1  host still owns the RX buffer (hostrx); sampled at frame start.
- buf_we  out  1  RX buffer write strobe.
- buf_addr  out  LEN_W  RX buffer byte address.
- buf_wdata  out  8  RX buffer write data.
- rx_busy  out  1  high while a frame is being written to the buffer.
- rx_done  out  1  one-cycle pulse: good frame complete.
- rx_len  out  LEN_W  length of the last good frame, FCS excluded; held until the next good frame.
- crc_ok  out  1  FCS result of the last non-dropped frame.
- n_dropped  out  LEN_W  frames dropped (buffer busy or overflow); saturates at all-ones.
- n_bad  out  LEN_W  frames rejected (FCS, runt, s_err); saturates at all-ones.

## Operation
- State RESYNC (the reset state): ignore all bytes. Go to IDLE on the first cycle with s_valid=0. This prevents treating the tail of a frame as a new frame after reset.
- State IDLE: a cycle with s_valid=1 is the first byte.
  - If host_busy=1: go to DROP.
  - Otherwise: write the byte at address 0, set cnt=1, initialise CRC, and go to RECV. If the first byte also has s_last=1, the frame is evaluated immediately as a runt.
- State RECV: each valid byte is written at address cnt, then cnt increments.
  - The CRC register (init 0xFFFFFFFF, reflected polynomial 0xEDB88320, LSB-first) is updated on every byte, including the FCS bytes.
  - A byte that would land at address ≥ MTU is not written; go to DROP. That frame counts in n_dropped, not n_bad.
  - Any byte with s_err=1 marks the frame bad; remaining bytes are still written.
- End of frame (byte with s_last=1 in RECV), where final length L = cnt + 1 including this byte:
  - Good if the CRC register after this byte equals 0xDEBB20E3, L ≥ 64, and no s_err was seen.
  - Good: rx_done=1, rx_len=L−4, crc_ok=1.
  - Bad: n_bad+1, crc_ok=0 if the CRC failed (otherwise 1), rx_len unchanged, no rx_done.
  - In both cases go to IDLE.
- State DROP: discard bytes without writing. On s_last: n_dropped+1 and go to IDLE.
- host_busy changes during RECV or DROP are ignored.
- Counters saturate and never wrap.

## Timing
- All outputs are registered.
- Byte accepted in cycle N → buf_we/buf_addr/buf_wdata valid in cycle N+1 for exactly one cycle. buf_we=0 otherwise.
- s_last accepted in cycle N:
  - Last buffer write, rx_done, rx_len, crc_ok and counter updates all appear in cycle N+1.
  - rx_busy falls in cycle N+1.
  - State is IDLE in N+1, so a new frame may start in cycle N+1 (zero gap supported).
- rx_busy rises in the cycle after the first byte of an accepted frame.
- Reset values: state=RESYNC, buf_we=0, buf_addr=0, buf_wdata=0, rx_busy=0, rx_done=0, rx_len=0, crc_ok=0, n_dropped=0, n_bad=0.
- Reset asserted mid-frame: all outputs return to reset values on the next edge. No further writes occur, and no counters change for that frame.
- Arithmetic: cnt is LEN_W bits. The overflow check compares cnt to MTU before writing. rx_len = L−4 is computed only when L ≥ 64, so it never underflows.

## Test plan
- Good frame: 60-byte payload plus correct FCS (64 bytes), host_busy=0 → 64 writes at addresses 0..63; rx_done one cycle after s_last; rx_len=60; crc_ok=1; counters 0.
- Corrupt FCS: flip bit 0 of byte 10 → all 64 bytes written; no rx_done; n_bad=1; crc_ok=0; rx_len keeps its previous value.
- Drop while busy: host_busy=1 at first byte, deasserted mid-frame → zero writes; n_dropped=1. A following good frame after host_busy=0 → rx_done, n_dropped stays 1.
- Overflow: 1600-byte frame with MTU=1536 → writes at addresses 0..1535 only; n_dropped=1; n_bad=0; no rx_done.
- Runt and error: 40-byte frame with valid FCS → n_bad=1. A 64-byte good-FCS frame with s_err on byte 20 → n_bad=2.
- Back-to-back and reset: two good frames with zero gap → two rx_done pulses. Reset asserted at byte 30 of a third frame → outputs at reset values; remaining bytes ignored in RESYNC; the next frame after an idle cycle is received normally.

Source files
------------

// File: rtl/eth_rx_framer.sv
// eth_rx_framer: receive framing stage feeding the RX buffer write port.
// Checks length and FCS, reports good frames, counts drops and rejects.
module eth_rx_framer #(
  parameter int MTU   = 1536,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  input  logic             s_err,
  input  logic             host_busy,
  output logic             buf_we,
  output logic [LEN_W-1:0] buf_addr,
  output logic [7:0]       buf_wdata,
  output logic             rx_busy,
  output logic             rx_done,
  output logic [LEN_W-1:0] rx_len,
  output logic             crc_ok,
  output logic [LEN_W-1:0] n_dropped,
  output logic [LEN_W-1:0] n_bad
);

  typedef enum logic [1:0] {
    S_RESYNC, S_IDLE, S_RECV, S_DROP
  } state_t;

  localparam logic [LEN_W-1:0] MTU_L = LEN_W'(MTU);
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(64);
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  state_t r_state, w_state_nxt;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_crc;
  logic             r_err;

  logic             w_idle, w_recv, w_fits;
  logic             w_accept, w_ovf, w_drop_end;
  logic [LEN_W-1:0] w_cnt_in;
  logic [31:0]      w_crc_in, w_crc_step;
  logic             w_err_acc, w_crc_match, w_good;

  logic             w_we, w_busy, w_done, w_ok;
  logic [LEN_W-1:0] w_addr, w_len, w_cnt_nxt;
  logic [7:0]       w_wdata;
  logic [31:0]      w_crc_nxt;
  logic             w_err_nxt, w_drop_inc, w_bad_inc;

  // One byte of the reflected CRC-32 (poly 0xEDB88320), LSB first.
  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] x;
    x = c;
    for (int i = 0; i < 8; i++) begin
      if (x[0] ^ d[i]) x = (x >> 1) ^ 32'hEDB88320;
      else             x = x >> 1;
    end
    return x;
  endfunction

  // A new frame starts from a fresh count and CRC seed.
  always_comb begin
    w_idle      = (r_state == S_IDLE);
    w_recv      = (r_state == S_RECV);
    w_cnt_in    = w_idle ? '0 : r_cnt;
    w_crc_in    = w_idle ? 32'hFFFFFFFF : r_crc;
    w_crc_step  = crc_byte(w_crc_in, s_data);
    w_crc_match = (w_crc_step == RESIDUE);
    w_err_acc   = (w_recv & r_err) | s_err;
    w_fits      = (w_cnt_in < MTU_L);
    w_accept    = s_valid & ((w_idle & ~host_busy) | (w_recv & w_fits));
    w_ovf       = s_valid & w_recv & ~w_fits;
    w_drop_end  = s_valid & s_last &
                  ((w_idle & host_busy) | (r_state == S_DROP) | w_ovf);
    w_good      = w_crc_match & ~w_err_acc &
                  ((w_cnt_in + LEN_W'(1)) >= MIN_L);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RESYNC;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RESYNC: if (!s_valid) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (s_valid && !s_last)
          w_state_nxt = host_busy ? S_DROP : S_RECV;
      end
      S_RECV: begin
        if (s_valid) begin
          if (s_last)      w_state_nxt = S_IDLE;
          else if (!w_fits) w_state_nxt = S_DROP;
        end
      end
      S_DROP: if (s_valid && s_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_RESYNC;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    w_we       = 1'b0;
    w_addr     = buf_addr;
    w_wdata    = buf_wdata;
    w_busy     = rx_busy;
    w_done     = 1'b0;
    w_len      = rx_len;
    w_ok       = crc_ok;
    w_cnt_nxt  = r_cnt;
    w_crc_nxt  = r_crc;
    w_err_nxt  = r_err;
    w_drop_inc = w_drop_end;
    w_bad_inc  = 1'b0;
    if (w_accept) begin
      w_we      = 1'b1;
      w_addr    = w_cnt_in;
      w_wdata   = s_data;
      w_busy    = ~s_last;
      w_cnt_nxt = w_cnt_in + LEN_W'(1);
      w_crc_nxt = w_crc_step;
      w_err_nxt = w_err_acc;
      if (s_last) begin
        if (w_good) begin
          w_done = 1'b1;
          w_len  = w_cnt_in - LEN_W'(3);
          w_ok   = 1'b1;
        end else begin
          w_bad_inc = 1'b1;
          w_ok      = w_crc_match;
        end
      end
    end else if (w_ovf) begin
      w_busy = 1'b0;
    end
  end

  // Output and datapath registers; counters saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      rx_busy   <= 1'b0;
      rx_done   <= 1'b0;
      rx_len    <= '0;
      crc_ok    <= 1'b0;
      n_dropped <= '0;
      n_bad     <= '0;
      r_cnt     <= '0;
      r_crc     <= 32'hFFFFFFFF;
      r_err     <= 1'b0;
    end else begin
      buf_we    <= w_we;
      buf_addr  <= w_addr;
      buf_wdata <= w_wdata;
      rx_busy   <= w_busy;
      rx_done   <= w_done;
      rx_len    <= w_len;
      crc_ok    <= w_ok;
      r_cnt     <= w_cnt_nxt;
      r_crc     <= w_crc_nxt;
      r_err     <= w_err_nxt;
      if (w_drop_inc && !(&n_dropped))
        n_dropped <= n_dropped + LEN_W'(1);
      if (w_bad_inc && !(&n_bad))
        n_bad <= n_bad + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_eth_rx_framer.sv
// tb_eth_rx_framer: directed and random frames against a frame-level
// model that judges each frame from its FCS field, length and flags.
module tb_eth_rx_framer;

  localparam int MTU   = 1536;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       s_data;
  logic             s_valid, s_last, s_err, host_busy;
  logic             buf_we, rx_busy, rx_done, crc_ok;
  logic [LEN_W-1:0] buf_addr, rx_len, n_dropped, n_bad;
  logic [7:0]       buf_wdata;

  eth_rx_framer #(.MTU(MTU), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_err(s_err), .host_busy(host_busy),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .rx_busy(rx_busy), .rx_done(rx_done), .rx_len(rx_len),
    .crc_ok(crc_ok), .n_dropped(n_dropped), .n_bad(n_bad)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:MTU-1];
  int wr_n = 0, done_n = 0, done_cyc = -1, bad_addr = 0;

  always @(negedge clk) begin
    if (buf_we) begin
      wr_n <= wr_n + 1;
      if (int'(buf_addr) < MTU) mem[buf_addr] <= buf_wdata;
      else bad_addr <= bad_addr + 1;
    end
    if (rx_done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
  end

  int tests = 0, fails = 0;
  logic [7:0] fr[$];
  int acc_cyc;
  int exp_len = 0, exp_ok = 0, exp_bad = 0, exp_drop = 0;
  int exp_wr, exp_done;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        c = ((c[0] ^ fr[i][b]) != 1'b0) ? ((c >> 1) ^ 32'hEDB88320)
                                          : (c >> 1);
    return ~c;
  endfunction

  task automatic make_frame(input int len);
    logic [31:0] c;
    fr.delete();
    for (int i = 0; i < len - 4; i++) fr.push_back(8'($urandom));
    c = crc32(len - 4);
    fr.push_back(c[7:0]);
    fr.push_back(c[15:8]);
    fr.push_back(c[23:16]);
    fr.push_back(c[31:24]);
  endtask

  function automatic bit fcs_ok();
    int n;
    n = fr.size();
    return crc32(n - 4) ==
           {fr[n-1], fr[n-2], fr[n-3], fr[n-4]};
  endfunction

  task automatic model(input int err_idx, input bit busy);
    int n;
    bit ok;
    n = fr.size();
    exp_done = 0;
    if (busy) begin
      exp_drop++;
      exp_wr = 0;
    end else if (n > MTU) begin
      exp_drop++;
      exp_wr = MTU;
    end else begin
      exp_wr = n;
      ok = fcs_ok();
      if (ok && n >= 64 && err_idx < 0) begin
        exp_done = 1;
        exp_len  = n - 4;
        exp_ok   = 1;
      end else begin
        exp_bad++;
        exp_ok = ok ? 1 : 0;
      end
    end
  endtask

  task automatic send(input int err_idx, input int busy_n,
                      input bit gap);
    for (int i = 0; i < fr.size(); i++) begin
      s_valid   = 1'b1;
      s_data    = fr[i];
      s_last    = (i == fr.size() - 1);
      s_err     = (i == err_idx);
      host_busy = (i < busy_n);
      @(posedge clk);
      #1;
    end
    acc_cyc = cyc;
    if (gap) begin
      s_valid   = 1'b0;
      s_last    = 1'b0;
      s_err     = 1'b0;
      host_busy = 1'b0;
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_rx_len"}, 32'(rx_len), 32'(exp_len));
    chk({tag, "_crc_ok"}, 32'(crc_ok), 32'(exp_ok));
    chk({tag, "_n_bad"}, 32'(n_bad), 32'(exp_bad));
    chk({tag, "_n_drop"}, 32'(n_dropped), 32'(exp_drop));
    chk({tag, "_busy"}, 32'(rx_busy), 32'd0);
  endtask

  task automatic chk_mem(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) if (mem[i] !== fr[i]) bad++;
    chk({tag, "_data"}, 32'(bad), 32'd0);
    chk({tag, "_addr"}, 32'(bad_addr), 32'd0);
  endtask

  task automatic run_frame(input string tag, input int err_idx,
                           input int busy_n);
    int w0, d0;
    w0 = wr_n;
    d0 = done_n;
    send(err_idx, busy_n, 1'b1);
    model(err_idx, busy_n > 0);
    repeat (2) @(negedge clk);
    #1;
    chk({tag, "_writes"}, 32'(wr_n - w0), 32'(exp_wr));
    chk({tag, "_done_n"}, 32'(done_n - d0), 32'(exp_done));
    if (exp_done == 1)
      chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(acc_cyc));
    chk_state(tag);
    chk_mem(tag, exp_wr);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_we"}, 32'(buf_we), 32'd0);
    chk({tag, "_addr"}, 32'(buf_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(buf_wdata), 32'd0);
    chk({tag, "_busy"}, 32'(rx_busy), 32'd0);
    chk({tag, "_done"}, 32'(rx_done), 32'd0);
    chk({tag, "_len"}, 32'(rx_len), 32'd0);
    chk({tag, "_ok"}, 32'(crc_ok), 32'd0);
    chk({tag, "_ndrop"}, 32'(n_dropped), 32'd0);
    chk({tag, "_nbad"}, 32'(n_bad), 32'd0);
  endtask

  initial begin
    int w0, d0, wa, n, idx, mode;
    rst = 1'b1;
    s_data = '0;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_err = 1'b0;
    host_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("rst0");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    make_frame(64);
    run_frame("good", -1, 0);

    make_frame(64);
    fr[10] = fr[10] ^ 8'h01;
    run_frame("badfcs", -1, 0);

    make_frame(64);
    run_frame("hostbusy", -1, 10);
    make_frame(64);
    run_frame("afterbusy", -1, 0);

    make_frame(1600);
    run_frame("overflow", -1, 0);

    make_frame(40);
    run_frame("runt", -1, 0);
    make_frame(64);
    run_frame("serr", 20, 0);

    w0 = wr_n;
    d0 = done_n;
    make_frame(64);
    send(-1, 0, 1'b0);
    model(-1, 1'b0);
    wa = exp_wr;
    make_frame(80);
    send(-1, 0, 1'b1);
    model(-1, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("b2b_writes", 32'(wr_n - w0), 32'(wa + exp_wr));
    chk("b2b_done_n", 32'(done_n - d0), 32'd2);
    chk("b2b_done_cyc", 32'(done_cyc), 32'(acc_cyc));
    chk_state("b2b");
    chk_mem("b2b", exp_wr);

    make_frame(64);
    for (int i = 0; i < 30; i++) begin
      s_valid = 1'b1;
      s_data  = fr[i];
      s_last  = 1'b0;
      s_err   = 1'b0;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("midrst_busy_pre", 32'(rx_busy), 32'd1);
    s_data = fr[30];
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    w0 = wr_n;
    s_data = fr[31];
    @(negedge clk);
    chk_reset_outs("midrst");
    @(posedge clk);
    #1;
    for (int i = 32; i < 64; i++) begin
      s_data = fr[i];
      s_last = (i == 63);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    @(posedge clk);
    #1;
    chk("resync_writes", 32'(wr_n - w0), 32'd0);
    chk("resync_nbad", 32'(n_bad), 32'd0);
    chk("resync_ndrop", 32'(n_dropped), 32'd0);
    exp_len = 0;
    exp_ok = 0;
    exp_bad = 0;
    exp_drop = 0;
    make_frame(72);
    run_frame("post_rst", -1, 0);

    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(130, 44);
      mode = $urandom_range(3, 0);
      make_frame(n);
      idx = $urandom_range(n - 1, 0);
      unique case (mode)
        0: run_frame("rnd_good", -1, 0);
        1: begin
          fr[idx] = fr[idx] ^ (8'h01 << $urandom_range(7, 0));
          run_frame("rnd_corrupt", -1, 0);
        end
        2: run_frame("rnd_serr", idx, 0);
        default: run_frame("rnd_busy", -1, idx + 1);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
